// File: rtl/prog_loader.sv
// Streaming byte-to-word program loader; holds the CPU in reset until the image is written.
// Optional checksum of written words: define LOADER_CHECKSUM_EN.
module prog_loader #(
  parameter int ADDR_WIDTH = 10,
  parameter int WORD_BYTES = 4,
  parameter int BIG_ENDIAN = 1
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    start,
  input  logic                    in_valid,
  input  logic [7:0]              in_byte,
  input  logic                    in_last,
  output logic                    in_ready,
  output logic                    mem_we,
  output logic [ADDR_WIDTH-1:0]   mem_addr,
  output logic [8*WORD_BYTES-1:0] mem_wdata,
  output logic                    cpu_hold,
  output logic                    busy,
  output logic                    done,
  output logic                    error,
  output logic [ADDR_WIDTH:0]     word_count,
  output logic [8*WORD_BYTES-1:0] chk_out
);

  localparam int DW = 8 * WORD_BYTES;
  localparam int SH = $clog2(WORD_BYTES);
  localparam int LW = (SH > 0) ? SH : 1;
  localparam int MAX_WORDS = (2 ** ADDR_WIDTH) / WORD_BYTES;
  localparam logic [ADDR_WIDTH:0] MAX_WC = (ADDR_WIDTH + 1)'(MAX_WORDS);
  localparam logic [LW-1:0] LAST_LANE = LW'(WORD_BYTES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_WRITE,
    S_DONE,
    S_ERROR
  } state_t;

  state_t              state;
  state_t              state_d;
  logic [LW-1:0]       lane;
  logic [LW-1:0]       pos;
  logic [DW-1:0]       asm_q;
  logic [DW-1:0]       placed;
  logic                last_q;
  logic [ADDR_WIDTH:0] wc;
  logic                accept;
  logic                full;
  logic                can_start;

  assign in_ready  = (state == S_LOAD);
  assign accept    = in_valid & in_ready;
  assign full      = (wc == MAX_WC);
  assign can_start = start & ((state == S_IDLE) |
                              (state == S_DONE) |
                              (state == S_ERROR));

  assign pos    = (BIG_ENDIAN != 0) ? (LAST_LANE - lane) : lane;
  assign placed = DW'(in_byte) << (32'(pos) << 3);

  assign mem_we     = (state == S_WRITE);
  assign mem_addr   = ADDR_WIDTH'(wc << SH);
  assign mem_wdata  = asm_q;
  assign busy       = (state == S_LOAD) | (state == S_WRITE);
  assign done       = (state == S_DONE);
  assign error      = (state == S_ERROR);
  assign cpu_hold   = (state != S_DONE);
  assign word_count = wc;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_d;
  end

  always_comb begin
    state_d = state;
    unique case (state)
      S_IDLE: if (start) state_d = S_LOAD;
      S_LOAD: begin
        if (accept) begin
          if (full)                           state_d = S_ERROR;
          else if (in_last || lane == LAST_LANE) state_d = S_WRITE;
        end
      end
      S_WRITE: state_d = last_q ? S_DONE : S_LOAD;
      S_DONE:  if (start) state_d = S_LOAD;
      S_ERROR: if (start) state_d = S_LOAD;
      default: state_d = S_IDLE;
    endcase
  end

  // Lanes start zeroed, so OR-ing each byte in leaves unfilled lanes padded.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      lane   <= '0;
      asm_q  <= '0;
      last_q <= 1'b0;
      wc     <= '0;
    end else if (can_start) begin
      lane   <= '0;
      asm_q  <= '0;
      last_q <= 1'b0;
      wc     <= '0;
    end else if (accept && !full) begin
      asm_q  <= asm_q | placed;
      lane   <= lane + LW'(1);
      last_q <= in_last;
    end else if (state == S_WRITE) begin
      lane  <= '0;
      asm_q <= '0;
      wc    <= wc + (ADDR_WIDTH + 1)'(1);
    end
  end

`ifdef LOADER_CHECKSUM_EN
  logic [DW-1:0] chk_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset)                chk_q <= '0;
    else if (can_start)        chk_q <= '0;
    else if (state == S_WRITE) chk_q <= chk_q ^ asm_q;
  end

  assign chk_out = chk_q;
`else
  assign chk_out = '0;
`endif

endmodule

// File: tb/tb_prog_loader.sv
// Bench for prog_loader: big-endian, little-endian and 2-word-capacity instances share one stream.
// Checks writes, latency, overflow, reset and checksum against a byte-grouping model.
module tb_prog_loader;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       start = 1'b0;
  logic       in_valid = 1'b0;
  logic [7:0] in_byte = 8'h00;
  logic       in_last = 1'b0;

  logic        rdy_a, we_a, hold_a, busy_a, done_a, err_a;
  logic [9:0]  addr_a;
  logic [31:0] wdata_a, chk_a;
  logic [10:0] wc_a;
  logic        rdy_b, we_b, hold_b, busy_b, done_b, err_b;
  logic [9:0]  addr_b;
  logic [31:0] wdata_b, chk_b;
  logic [10:0] wc_b;
  logic        rdy_c, we_c, hold_c, busy_c, done_c, err_c;
  logic [2:0]  addr_c;
  logic [31:0] wdata_c, chk_c;
  logic [3:0]  wc_c;

  always #5 clock = ~clock;

  prog_loader u_be (
    .clock(clock), .reset(reset), .start(start), .in_valid(in_valid),
    .in_byte(in_byte), .in_last(in_last), .in_ready(rdy_a), .mem_we(we_a),
    .mem_addr(addr_a), .mem_wdata(wdata_a), .cpu_hold(hold_a),
    .busy(busy_a), .done(done_a), .error(err_a), .word_count(wc_a),
    .chk_out(chk_a)
  );

  prog_loader #(.BIG_ENDIAN(0)) u_le (
    .clock(clock), .reset(reset), .start(start), .in_valid(in_valid),
    .in_byte(in_byte), .in_last(in_last), .in_ready(rdy_b), .mem_we(we_b),
    .mem_addr(addr_b), .mem_wdata(wdata_b), .cpu_hold(hold_b),
    .busy(busy_b), .done(done_b), .error(err_b), .word_count(wc_b),
    .chk_out(chk_b)
  );

  prog_loader #(.ADDR_WIDTH(3)) u_sm (
    .clock(clock), .reset(reset), .start(start), .in_valid(in_valid),
    .in_byte(in_byte), .in_last(in_last), .in_ready(rdy_c), .mem_we(we_c),
    .mem_addr(addr_c), .mem_wdata(wdata_c), .cpu_hold(hold_c),
    .busy(busy_c), .done(done_c), .error(err_c), .word_count(wc_c),
    .chk_out(chk_c)
  );

  logic [2:0]  rdy, we, hold, bsy, dn, er;
  logic [31:0] addr_v [3];
  logic [31:0] data_v [3];
  logic [31:0] chk_v  [3];
  logic [31:0] wc_v   [3];

  assign rdy  = {rdy_c, rdy_b, rdy_a};
  assign we   = {we_c, we_b, we_a};
  assign hold = {hold_c, hold_b, hold_a};
  assign bsy  = {busy_c, busy_b, busy_a};
  assign dn   = {done_c, done_b, done_a};
  assign er   = {err_c, err_b, err_a};
  assign addr_v[0] = 32'(addr_a);
  assign addr_v[1] = 32'(addr_b);
  assign addr_v[2] = 32'(addr_c);
  assign data_v[0] = wdata_a;
  assign data_v[1] = wdata_b;
  assign data_v[2] = wdata_c;
  assign chk_v[0]  = chk_a;
  assign chk_v[1]  = chk_b;
  assign chk_v[2]  = chk_c;
  assign wc_v[0]   = 32'(wc_a);
  assign wc_v[1]   = 32'(wc_b);
  assign wc_v[2]   = 32'(wc_c);

  int checks = 0;
  int errors = 0;
  int viol   = 0;

  logic [63:0] wq [3][$];
  logic [7:0]  stim [$];
  logic [31:0] exp_q [$];
  bit          exp_err;

  always @(negedge clock) begin
    for (int i = 0; i < 3; i++) begin
      if (we[i]) wq[i].push_back({addr_v[i], data_v[i]});
      if (we[i] && rdy[i]) viol++;
    end
  end

  // Group the stream into 4-byte words, pad the tail, stop at capacity.
  function automatic void build_model(input bit big, input int maxw);
    int n;
    int nw;
    logic [31:0] word;
    n = stim.size();
    nw = (n + 3) / 4;
    exp_q.delete();
    exp_err = (nw > maxw);
    if (nw > maxw) nw = maxw;
    for (int w = 0; w < nw; w++) begin
      word = '0;
      for (int k = 0; k < 4; k++) begin
        if (w * 4 + k < n) begin
          if (big) word[31 - 8 * k -: 8] = stim[w * 4 + k];
          else     word[8 * k +: 8] = stim[w * 4 + k];
        end
      end
      exp_q.push_back(word);
    end
  endfunction

  task automatic do_start();
    @(negedge clock);
    for (int i = 0; i < 3; i++) wq[i].delete();
    viol = 0;
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
  endtask

  // Entered at a negedge; returns at the negedge just after the final accept.
  task automatic send(input bit gaps, input bit with_last);
    int  n;
    int  budget;
    bit  took;
    bit  r;
    n = stim.size();
    for (int i = 0; i < n; i++) begin
      took = 1'b0;
      budget = 0;
      while (!took) begin
        in_valid = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
        in_byte  = in_valid ? stim[i] : 8'($urandom);
        in_last  = in_valid && with_last && (i == n - 1);
        r = rdy[0];
        @(posedge clock);
        took = in_valid && r;
        @(negedge clock);
        budget++;
        if (!took && budget > 60) begin
          checks++;
          errors++;
          $display("FAIL send_timeout byte=%0d in_ready stayed %b, required 1", i, rdy[0]);
          in_valid = 1'b0;
          in_last = 1'b0;
          return;
        end
      end
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    #2;
    checks++;
    if ({rdy_a, we_a, busy_a, done_a, err_a} !== 5'b0) begin
      errors++;
      $display("FAIL reset_flags got %b required 00000", {rdy_a, we_a, busy_a, done_a, err_a});
    end
    checks++;
    if (hold_a !== 1'b1) begin
      errors++;
      $display("FAIL reset_hold got %b required 1", hold_a);
    end
    checks++;
    if ({addr_a, wdata_a, wc_a, chk_a} !== '0) begin
      errors++;
      $display("FAIL reset_data addr=%h data=%h wc=%0d chk=%h required all 0", addr_a, wdata_a, wc_a, chk_a);
    end
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
  endtask

  task automatic test_fixed();
    logic [31:0] chk_exp;
    stim = '{8'h00, 8'hC5, 8'h87, 8'hB3};
    do_start();
    send(1'b0, 1'b1);
    checks++;
    if (we[0] !== 1'b1 || dn[0] !== 1'b0) begin
      errors++;
      $display("FAIL fixed_lat_we we=%b done=%b required we=1 done=0", we[0], dn[0]);
    end
    @(negedge clock);
    checks++;
    if (dn[0] !== 1'b1 || hold[0] !== 1'b0) begin
      errors++;
      $display("FAIL fixed_lat_done done=%b hold=%b required done=1 hold=0", dn[0], hold[0]);
    end
    @(negedge clock);
    checks++;
    if (wq[0].size() != 1 || wq[0][0] !== {32'h0, 32'h00C587B3}) begin
      errors++;
      $display("FAIL fixed_be writes=%0d first=%h required 1 write 00000000_00c587b3", wq[0].size(), wq[0][0]);
    end
    checks++;
    if (wq[1].size() != 1 || wq[1][0] !== {32'h0, 32'hB387C500}) begin
      errors++;
      $display("FAIL fixed_le writes=%0d first=%h required 1 write 00000000_b387c500", wq[1].size(), wq[1][0]);
    end
    checks++;
    if (wc_v[0] !== 32'd1) begin
      errors++;
      $display("FAIL fixed_wc got %0d required 1", wc_v[0]);
    end
`ifdef LOADER_CHECKSUM_EN
    chk_exp = 32'h00C587B3;
`else
    chk_exp = 32'h0;
`endif
    checks++;
    if (chk_v[0] !== chk_exp) begin
      errors++;
      $display("FAIL fixed_chk got %h required %h", chk_v[0], chk_exp);
    end
  endtask

  task automatic test_six();
    stim = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
    do_start();
    send(1'b1, 1'b1);
    repeat (2) @(negedge clock);
    checks++;
    if (wq[0].size() != 2 || wq[0][0] !== {32'h0, 32'h11223344} ||
        wq[0][1] !== {32'h4, 32'h55660000}) begin
      errors++;
      $display("FAIL six_writes n=%0d w0=%h w1=%h required 2 writes @0 11223344, @4 55660000",
               wq[0].size(), wq[0][0], wq[0][1]);
    end
    checks++;
    if (wc_v[0] !== 32'd2) begin
      errors++;
      $display("FAIL six_wc got %0d required 2", wc_v[0]);
    end
    checks++;
    if (viol !== 0) begin
      errors++;
      $display("FAIL six_bubble in_ready high during %0d write cycles, required 0", viol);
    end
  endtask

  task automatic test_checksum();
    logic [31:0] chk_exp;
    stim = '{8'h00, 8'hC5, 8'h87, 8'hB3, 8'h12, 8'h34, 8'h56, 8'h78};
    do_start();
    send(1'b1, 1'b1);
    repeat (2) @(negedge clock);
`ifdef LOADER_CHECKSUM_EN
    chk_exp = 32'h12F1D1CB;
`else
    chk_exp = 32'h0;
`endif
    checks++;
    if (dn[0] !== 1'b1 || chk_v[0] !== chk_exp) begin
      errors++;
      $display("FAIL checksum done=%b chk=%h required done=1 chk=%h", dn[0], chk_v[0], chk_exp);
    end
  endtask

  task automatic test_overflow();
    stim = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'h09};
    do_start();
    send(1'b0, 1'b1);
    repeat (3) @(negedge clock);
    checks++;
    if (wq[2].size() != 2 || wq[2][0] !== {32'h0, 32'h01020304} ||
        wq[2][1] !== {32'h4, 32'h05060708}) begin
      errors++;
      $display("FAIL ovf_writes n=%0d w0=%h w1=%h required 2 writes @0 01020304, @4 05060708",
               wq[2].size(), wq[2][0], wq[2][1]);
    end
    checks++;
    if (er[2] !== 1'b1 || hold[2] !== 1'b1 || rdy[2] !== 1'b0) begin
      errors++;
      $display("FAIL ovf_state error=%b hold=%b ready=%b required 1 1 0", er[2], hold[2], rdy[2]);
    end
    checks++;
    if (dn[0] !== 1'b1 || wc_v[0] !== 32'd3) begin
      errors++;
      $display("FAIL ovf_big done=%b wc=%0d required done=1 wc=3", dn[0], wc_v[0]);
    end
    do_start();
    checks++;
    if (er[2] !== 1'b0 || bsy[2] !== 1'b1) begin
      errors++;
      $display("FAIL ovf_restart error=%b busy=%b required 0 1", er[2], bsy[2]);
    end
    stim = '{8'hAA};
    send(1'b0, 1'b1);
    repeat (2) @(negedge clock);
  endtask

  task automatic test_reset_mid();
    stim = '{8'($urandom), 8'($urandom)};
    do_start();
    send(1'b1, 1'b0);
    reset = 1'b0;
    #2;
    checks++;
    if ({rdy_a, we_a, busy_a, done_a, err_a, hold_a} !== 6'b000001 ||
        {addr_a, wdata_a, wc_a, chk_a} !== '0) begin
      errors++;
      $display("FAIL midreset flags=%b addr=%h data=%h wc=%0d chk=%h required 000001 and zeros",
               {rdy_a, we_a, busy_a, done_a, err_a, hold_a}, addr_a, wdata_a, wc_a, chk_a);
    end
    @(negedge clock);
    reset = 1'b1;
    stim = '{8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom)};
    do_start();
    send(1'b1, 1'b1);
    repeat (2) @(negedge clock);
    build_model(1'b1, 256);
    checks++;
    if (wq[0].size() != 1 || wq[0][0] !== {32'h0, exp_q[0]}) begin
      errors++;
      $display("FAIL midreset_restart n=%0d got %h required 1 write %h",
               wq[0].size(), wq[0][0], {32'h0, exp_q[0]});
    end
  endtask

  task automatic test_random();
    int n;
    logic [63:0] got;
    logic [63:0] want;
    logic [31:0] x;
    for (int it = 0; it < 8; it++) begin
      n = $urandom_range(1, 12);
      stim.delete();
      for (int i = 0; i < n; i++) stim.push_back(8'($urandom));
      do_start();
      send(1'b1, 1'b1);
      checks++;
      if (we[0] !== 1'b1) begin
        errors++;
        $display("FAIL rand_lat_we it=%0d got %b required 1", it, we[0]);
      end
      @(negedge clock);
      checks++;
      if (dn[0] !== 1'b1 || hold[0] !== 1'b0) begin
        errors++;
        $display("FAIL rand_lat_done it=%0d done=%b hold=%b required 1 0", it, dn[0], hold[0]);
      end
      @(negedge clock);
      for (int d = 0; d < 3; d++) begin
        build_model(d != 1, (d == 2) ? 2 : 256);
        checks++;
        if (wq[d].size() != exp_q.size()) begin
          errors++;
          $display("FAIL rand_count it=%0d dut=%0d got %0d writes required %0d",
                   it, d, wq[d].size(), exp_q.size());
        end
        x = '0;
        for (int j = 0; j < exp_q.size(); j++) begin
          got = (j < wq[d].size()) ? wq[d][j] : 64'hx;
          want = {32'(j * 4), exp_q[j]};
          x = x ^ exp_q[j];
          checks++;
          if (got !== want) begin
            errors++;
            $display("FAIL rand_word it=%0d dut=%0d idx=%0d got %h required %h", it, d, j, got, want);
          end
        end
        checks++;
        if (wc_v[d] !== 32'(exp_q.size()) || dn[d] !== !exp_err || er[d] !== exp_err) begin
          errors++;
          $display("FAIL rand_status it=%0d dut=%0d wc=%0d done=%b error=%b required %0d %b %b",
                   it, d, wc_v[d], dn[d], er[d], exp_q.size(), !exp_err, exp_err);
        end
`ifndef LOADER_CHECKSUM_EN
        x = '0;
`endif
        checks++;
        if (chk_v[d] !== x) begin
          errors++;
          $display("FAIL rand_chk it=%0d dut=%0d got %h required %h", it, d, chk_v[d], x);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_fixed();
    test_six();
    test_checksum();
    test_overflow();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
